ps2_host_tx: RTL and testbench

//  PS/2 host-to-device transmitter: sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xEE echo.

---
 rtl/ps2_host_tx_pkg.sv | 16 +
 rtl/ps2_host_tx_line_sync.sv | 29 ++
 rtl/ps2_host_tx.sv | 127 ++++++++++++
 tb/tb_ps2_host_tx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: shared PS/2 host transmitter types, command constants and frame builder
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, DATA, ACK, WAIT_IDLE} ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

  // {stop, odd parity, data}; shifted out from bit 0 upward
  function automatic logic [9:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_sync.sv
// ps2_line_sync: 2-FF synchronizer for PS/2 clock and data pins plus a clock falling-edge strobe
module ps2_line_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic clock_in,
  input  logic data_in,
  output logic clock_sync,
  output logic data_sync,
  output logic fall
);
  logic [1:0] clk_ff;
  logic [1:0] dat_ff;
  logic       clk_prev;
  // idle PS/2 lines are high, so every stage resets to 1 to avoid a false fall after reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      clk_ff   <= 2'b11;
      dat_ff   <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], clock_in};
      dat_ff   <= {dat_ff[0], data_in};
      clk_prev <= clk_ff[1];
    end
  end
  assign clock_sync = clk_ff[1];
  assign data_sync  = dat_ff[1];
  assign fall       = clk_prev & ~clk_ff[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter; define PS2_TX_AUTO_RETRY_EN to retry failed frames
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000
`ifdef PS2_TX_AUTO_RETRY_EN
  , parameter int MAX_RETRY    = 2
`endif
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_block
);
  localparam int CW = $clog2((INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES) + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_t state;
  logic [CW-1:0] cnt;
  logic [3:0]    bitcnt;
  logic [9:0]    frame;
  logic          nack;
  logic          clk_s, dat_s, fall;
  logic          timeout, idle_ok, ending, err, retry_now;

  ps2_line_sync u_sync (
    .clock      (clock),
    .reset_n    (reset_n),
    .clock_in   (ps2_clock_in),
    .data_in    (ps2_data_in),
    .clock_sync (clk_s),
    .data_sync  (dat_s),
    .fall       (fall)
  );

  // frame termination: watchdog expiry while the device owns the clock, or bus idle after the ack slot
  always_comb begin
    timeout = (state inside {REQ, DATA, ACK, WAIT_IDLE}) && !fall && cnt == TO_LAST;
    idle_ok = state == WAIT_IDLE && clk_s && dat_s;
    ending  = timeout || idle_ok;
    err     = timeout || nack;
  end

`ifdef PS2_TX_AUTO_RETRY_EN
  logic [7:0] retry;
  assign retry_now = ending && err && retry < 8'(MAX_RETRY);
  // attempts used for the current byte; cleared whenever the transmitter is idle
  always_ff @(posedge clock) begin
    if (!reset_n || state == IDLE) retry <= '0;
    else if (retry_now) retry <= retry + 8'd1;
  end
`else
  assign retry_now = 1'b0;
`endif

  // transmit FSM with registered pin enables and handshake outputs
  always_ff @(posedge clock) begin
    tx_done <= 1'b0;
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      bitcnt       <= '0;
      frame        <= '0;
      nack         <= 1'b0;
      ps2_clock_oe <= 1'b0;
      ps2_data_oe  <= 1'b0;
      tx_ready     <= 1'b1;
      tx_error     <= 1'b0;
      rx_block     <= 1'b0;
    end else if (retry_now) begin
      state        <= INHIBIT;
      cnt          <= '0;
      ps2_clock_oe <= 1'b1;
      ps2_data_oe  <= 1'b0;
    end else if (ending) begin
      state        <= IDLE;
      ps2_clock_oe <= 1'b0;
      ps2_data_oe  <= 1'b0;
      tx_ready     <= 1'b1;
      rx_block     <= 1'b0;
      tx_done      <= 1'b1;
      tx_error     <= err;
    end else begin
      case (state)
        IDLE: if (tx_valid) begin
          frame        <= ps2_frame(tx_data);
          state        <= INHIBIT;
          cnt          <= '0;
          ps2_clock_oe <= 1'b1;
          tx_ready     <= 1'b0;
          rx_block     <= 1'b1;
        end
        INHIBIT: if (cnt == INH_LAST) begin
          state        <= REQ;
          cnt          <= '0;
          ps2_clock_oe <= 1'b0;
          ps2_data_oe  <= 1'b1;
        end else cnt <= cnt + 1'b1;
        default: if (fall) begin
          cnt <= '0;
          if (state == REQ) begin
            ps2_data_oe <= ~frame[0];
            bitcnt      <= 4'd1;
            state       <= DATA;
          end else if (state == DATA) begin
            ps2_data_oe <= ~frame[bitcnt];
            bitcnt      <= bitcnt + 4'd1;
            if (bitcnt == 4'd9) state <= ACK;
          end else if (state == ACK) begin
            nack  <= dat_s;
            state <= WAIT_IDLE;
          end
        end else cnt <= cnt + 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench for ps2_host_tx with an open-drain PS/2 device model
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  typedef struct {
    logic err;
    int   kind;
    int   lat;
    int   coe;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       ps2_clock_oe, ps2_data_oe, tx_ready, tx_done, tx_error, rx_block;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clock_in, ps2_data_in;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   req_cyc = 0;
  int   edge_cyc = 0;
  int   dev_edges = 0;
  int   coe_cnt = 0;
  int   viol = 0;
  bit   in_frame = 0;
  logic prev_doe = 1'b0;

  assign ps2_clock_in = ~(ps2_clock_oe | dev_clk_low);
  assign ps2_data_in  = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(200)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ps2_clock_in (ps2_clock_in),
    .ps2_data_in  (ps2_data_in),
    .ps2_clock_oe (ps2_clock_oe),
    .ps2_data_oe  (ps2_data_oe),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_done      (tx_done),
    .tx_error     (tx_error),
    .rx_block     (rx_block)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // monitor: busy-flag tracking and scoreboard pop on every tx_done
  always @(negedge clock) begin
    if (reset_n) begin
      if (ps2_data_oe && !prev_doe) req_cyc = cyc;
      prev_doe = ps2_data_oe;
      if (in_frame && !tx_done) begin
        if (ps2_clock_oe) coe_cnt++;
        if (!rx_block || tx_ready) viol++;
      end
      if (tx_done) begin
        if (exp_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("tx_error", tx_error, e.err);
          check("busy_flags", viol, 0);
          check("released", {ps2_clock_oe, ps2_data_oe}, 0);
          check("clock_oe_cycles", coe_cnt, e.coe);
          if (e.kind == 1) check("req_to_done", cyc - req_cyc, e.lat);
          else if (e.kind == 2) check("edge_to_done", cyc - edge_cyc, e.lat);
        end
        in_frame = 0;
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic err, input int kind, input int lat, input int coe);
    @(negedge clock);
    tx_data  = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 1000 && !tx_ready; i++) @(negedge clock);
    if (!tx_ready) check("accept_timeout", 0, 1);
    @(posedge clock);
    exp_q.push_back('{err, kind, lat, coe});
    in_frame = 1;
    coe_cnt  = 0;
    viol     = 0;
    @(negedge clock);
    tx_valid = 1'b0;
  endtask

  // device: n clock pulses (11 = full frame plus ack slot), 40-clock period
  task automatic device(input int n, input logic ack, input logic [9:0] want);
    logic [9:0] got;
    int w;
    got = '0;
    w = 0;
    while (!(ps2_clock_in && !ps2_data_in) && w < 2000) begin
      @(negedge clock);
      w++;
    end
    if (w >= 2000) begin
      check("device_req_timeout", 0, 1);
      return;
    end
    for (int i = 1; i <= n && i <= 10; i++) begin
      repeat (20) @(negedge clock);
      dev_clk_low = 1'b1;
      edge_cyc = cyc;
      dev_edges++;
      repeat (20) @(negedge clock);
      got[i-1] = ps2_data_in;
      dev_clk_low = 1'b0;
    end
    if (n >= 11) begin
      check("device_frame", got, want);
      repeat (10) @(negedge clock);
      dev_data_low = ack;
      repeat (10) @(negedge clock);
      dev_clk_low = 1'b1;
      dev_edges++;
      repeat (20) @(negedge clock);
      dev_clk_low = 1'b0;
      repeat (5) @(negedge clock);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && exp_q.size() > 0; i++) @(negedge clock);
    if (exp_q.size() > 0) begin
      check("done_timeout", 0, 1);
      exp_q.delete();
    end
    repeat (5) @(negedge clock);
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clock);
    check("rst_clock_oe", ps2_clock_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_tx_done", tx_done, 0);
    check("rst_tx_error", tx_error, 0);
    check("rst_rx_block", rx_block, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);

    send(PS2_CMD_SET_LEDS, 1'b0, 0, 0, 20);
    device(11, 1'b1, 10'h3ED);
    wait_idle();

    send(8'h02, 1'b0, 0, 0, 20);
    device(11, 1'b1, 10'h202);
    wait_idle();

    send(PS2_CMD_ECHO, 1'b1, 1, 200, 20);
    wait_idle();

    send(PS2_CMD_SET_LEDS, 1'b1, 2, 203, 20);
    device(5, 1'b1, 10'h000);
    wait_idle();

`ifdef PS2_TX_AUTO_RETRY_EN
    send(PS2_CMD_ECHO, 1'b1, 0, 0, 60);
    repeat (3) device(11, 1'b0, 10'h3EE);
`else
    send(PS2_CMD_ECHO, 1'b1, 0, 0, 20);
    device(11, 1'b0, 10'h3EE);
`endif
    wait_idle();

    send(PS2_CMD_RESET, 1'b0, 0, 0, 20);
    base = dev_edges;
    fork
      device(4, 1'b1, 10'h000);
      begin
        for (int i = 0; i < 2000 && dev_edges < base + 4; i++) @(negedge clock);
        repeat (6) @(negedge clock);
        in_frame = 0;
        reset_n = 1'b0;
        @(negedge clock);
        check("midrst_clock_oe", ps2_clock_oe, 0);
        check("midrst_data_oe", ps2_data_oe, 0);
        check("midrst_tx_ready", tx_ready, 1);
        check("midrst_rx_block", rx_block, 0);
        check("midrst_tx_done", tx_done, 0);
        reset_n = 1'b1;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
      end
    join
    repeat (300) @(negedge clock);
    check("midrst_no_done", exp_q.size(), 0);

    send(PS2_CMD_RESET, 1'b0, 0, 0, 20);
    device(11, 1'b1, 10'h3FF);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
